// File: rtl/compute_work_pipe.sv
// Two-stage compute/work pipeline with valid/ready handshaking on both sides.
// S1 computes add/sub/accumulate/clear; S2 holds the sum and its derived work value.
module compute_work_pipe #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [1:0]       mode_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH:0]   sum_o,
    output logic [WIDTH:0]   work_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             overflow_o
);

    localparam logic [1:0] MODE_ADD   = 2'b00;
    localparam logic [1:0] MODE_SUB   = 2'b01;
    localparam logic [1:0] MODE_ACC   = 2'b10;
    localparam logic [1:0] MODE_CLEAR = 2'b11;

    logic             v1;
    logic             v2;
    logic [WIDTH:0]   s1_sum;
    logic [WIDTH:0]   acc;
    logic [WIDTH+1:0] acc_ext;
    logic             acc_carry;
    logic [WIDTH:0]   acc_next;
    logic [WIDTH:0]   result;
    logic             adv2;
    logic             adv1;
    logic             accept;

    assign adv2    = ~v2 | ready_i;
    assign adv1    = ~v1 | adv2;
    assign ready_o = adv1;
    assign accept  = valid_i & adv1;
    assign valid_o = v2;

    always_comb begin
        acc_ext   = {1'b0, acc} + {2'b00, a_i};
        acc_carry = acc_ext[WIDTH+1];
        acc_next  = (SATURATE && acc_carry) ? '1 : acc_ext[WIDTH:0];
        case (mode_i)
            MODE_ADD:   result = {1'b0, a_i} + {1'b0, b_i};
            MODE_SUB:   result = {1'b0, a_i} - {1'b0, b_i};
            MODE_ACC:   result = acc_next;
            MODE_CLEAR: result = '0;
            default:    result = '0;
        endcase
    end

    // Accumulator and overflow flag move only on an accepted transaction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc        <= '0;
            overflow_o <= 1'b0;
        end else if (accept) begin
            if (mode_i == MODE_ACC) begin
                acc <= acc_next;
                if (acc_carry)
                    overflow_o <= 1'b1;
            end else if (mode_i == MODE_CLEAR) begin
                acc        <= '0;
                overflow_o <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v1     <= 1'b0;
            s1_sum <= '0;
        end else if (adv1) begin
            v1 <= accept;
            if (accept)
                s1_sum <= result;
        end
    end

    // work is derived from the S1 sum as it moves into S2, so both outputs change together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v2     <= 1'b0;
            sum_o  <= '0;
            work_o <= '0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                sum_o  <= s1_sum;
                work_o <= {1'b1, ~s1_sum[WIDTH-1:0]};
            end
        end
    end

endmodule

// File: tb/tb_compute_work_pipe.sv
// Directed bench for compute_work_pipe (WIDTH=8), one wrapping and one saturating instance.
module tb_compute_work_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a_in = '0;
    logic [7:0] b_in = '0;
    logic [1:0] mode = '0;
    logic       valid_in = 1'b0;
    logic       ready_in = 1'b1;

    logic       ready_w, valid_w, ovf_w;
    logic [8:0] sum_w, work_w;
    logic       ready_s, valid_s, ovf_s;
    logic [8:0] sum_s, work_s;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    compute_work_pipe #(.WIDTH(8), .SATURATE(1'b0)) dut (
        .clk_i(clk), .rst_i(rst), .a_i(a_in), .b_i(b_in), .mode_i(mode),
        .valid_i(valid_in), .ready_o(ready_w), .sum_o(sum_w), .work_o(work_w),
        .valid_o(valid_w), .ready_i(ready_in), .overflow_o(ovf_w)
    );

    compute_work_pipe #(.WIDTH(8), .SATURATE(1'b1)) dut_sat (
        .clk_i(clk), .rst_i(rst), .a_i(a_in), .b_i(b_in), .mode_i(mode),
        .valid_i(valid_in), .ready_o(ready_s), .sum_o(sum_s), .work_o(work_s),
        .valid_o(valid_s), .ready_i(ready_in), .overflow_o(ovf_s)
    );

    // Present one transaction on an empty pipe with ready_in high; returns with its output valid.
    task automatic xfer(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
        mode = m; a_in = a; b_in = b; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        #2;
        checks++; if (ready_w !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready_w); end
        checks++; if (valid_w !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_w); end
        checks++; if (ovf_w !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf_w); end
        checks++; if (sum_w !== 9'h000 || work_w !== 9'h000) begin failures++; $display("FAIL reset_data sum=%h work=%h exp=000/000", sum_w, work_w); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_add;
        mode = 2'b00; a_in = 8'd200; b_in = 8'd100; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        checks++; if (valid_w !== 1'b0) begin failures++; $display("FAIL add_latency1 valid=%b exp=0", valid_w); end
        @(posedge clk); #1;
        checks++; if (valid_w !== 1'b1) begin failures++; $display("FAIL add_valid got=%b exp=1", valid_w); end
        checks++; if (sum_w !== 9'h12C) begin failures++; $display("FAIL add_sum got=%h exp=12c", sum_w); end
        checks++; if (work_w !== 9'h1D3) begin failures++; $display("FAIL add_work got=%h exp=1d3", work_w); end
        @(posedge clk); #1;
        checks++; if (valid_w !== 1'b0) begin failures++; $display("FAIL add_drain valid=%b exp=0", valid_w); end
    endtask

    task automatic test_sub;
        xfer(2'b11, 8'd0, 8'd0);
        xfer(2'b10, 8'd10, 8'd99);
        checks++; if (sum_w !== 9'h00A) begin failures++; $display("FAIL sub_preacc got=%h exp=00a", sum_w); end
        xfer(2'b01, 8'd5, 8'd7);
        checks++; if (sum_w !== 9'h1FE) begin failures++; $display("FAIL sub_sum got=%h exp=1fe", sum_w); end
        checks++; if (work_w !== 9'h101) begin failures++; $display("FAIL sub_work got=%h exp=101", work_w); end
        checks++; if (ovf_w !== 1'b0) begin failures++; $display("FAIL sub_ovf got=%b exp=0", ovf_w); end
        xfer(2'b10, 8'd1, 8'd0);
        checks++; if (sum_w !== 9'h00B) begin failures++; $display("FAIL sub_acc_kept got=%h exp=00b", sum_w); end
    endtask

    task automatic test_accumulate;
        xfer(2'b11, 8'd0, 8'd0);
        checks++; if (sum_w !== 9'h000 || work_w !== 9'h1FF) begin failures++; $display("FAIL acc_clear sum=%h work=%h exp=000/1ff", sum_w, work_w); end
        xfer(2'b10, 8'd255, 8'd0);
        checks++; if (sum_w !== 9'h0FF || sum_s !== 9'h0FF) begin failures++; $display("FAIL acc_1 wrap=%h sat=%h exp=0ff/0ff", sum_w, sum_s); end
        xfer(2'b10, 8'd255, 8'd0);
        checks++; if (sum_w !== 9'h1FE || ovf_w !== 1'b0) begin failures++; $display("FAIL acc_2 sum=%h ovf=%b exp=1fe/0", sum_w, ovf_w); end
        xfer(2'b10, 8'd255, 8'd0);
        checks++; if (sum_w !== 9'h0FD) begin failures++; $display("FAIL acc_3_wrap got=%h exp=0fd", sum_w); end
        checks++; if (sum_s !== 9'h1FF) begin failures++; $display("FAIL acc_3_sat got=%h exp=1ff", sum_s); end
        checks++; if (ovf_w !== 1'b1 || ovf_s !== 1'b1) begin failures++; $display("FAIL acc_3_ovf wrap=%b sat=%b exp=1/1", ovf_w, ovf_s); end
        xfer(2'b00, 8'd1, 8'd1);
        checks++; if (sum_w !== 9'h002 || ovf_w !== 1'b1) begin failures++; $display("FAIL acc_sticky sum=%h ovf=%b exp=002/1", sum_w, ovf_w); end
        xfer(2'b11, 8'd7, 8'd7);
        checks++; if (sum_w !== 9'h000 || valid_w !== 1'b1) begin failures++; $display("FAIL acc_clear2 sum=%h valid=%b exp=000/1", sum_w, valid_w); end
        checks++; if (ovf_w !== 1'b0 || ovf_s !== 1'b0) begin failures++; $display("FAIL acc_clear_ovf wrap=%b sat=%b exp=0/0", ovf_w, ovf_s); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        ready_in = 1'b0;
        mode = 2'b00; a_in = 8'd1; b_in = 8'd1; valid_in = 1'b1;
        @(posedge clk); #1;
        a_in = 8'd2; b_in = 8'd2;
        checks++; if (ready_w !== 1'b1) begin failures++; $display("FAIL b2b_ready2 got=%b exp=1", ready_w); end
        @(posedge clk); #1;
        a_in = 8'd3; b_in = 8'd3;
        checks++; if (ready_w !== 1'b0) begin failures++; $display("FAIL b2b_ready3 got=%b exp=0", ready_w); end
        checks++; if (valid_w !== 1'b1 || sum_w !== 9'h002) begin failures++; $display("FAIL b2b_head valid=%b sum=%h exp=1/002", valid_w, sum_w); end
        @(posedge clk); #1;
        checks++; if (valid_w !== 1'b1 || sum_w !== 9'h002 || work_w !== 9'h1FD) begin failures++; $display("FAIL b2b_hold valid=%b sum=%h work=%h exp=1/002/1fd", valid_w, sum_w, work_w); end
        ready_in = 1'b1;
        #1;
        checks++; if (ready_w !== 1'b1) begin failures++; $display("FAIL b2b_release_ready got=%b exp=1", ready_w); end
        @(posedge clk); #1;
        valid_in = 1'b0;
        checks++; if (valid_w !== 1'b1 || sum_w !== 9'h004) begin failures++; $display("FAIL b2b_second valid=%b sum=%h exp=1/004", valid_w, sum_w); end
        @(posedge clk); #1;
        checks++; if (valid_w !== 1'b1 || sum_w !== 9'h006) begin failures++; $display("FAIL b2b_third valid=%b sum=%h exp=1/006", valid_w, sum_w); end
        @(posedge clk); #1;
        checks++; if (valid_w !== 1'b0) begin failures++; $display("FAIL b2b_drain valid=%b exp=0", valid_w); end
    endtask

    task automatic test_reset_midflight;
        xfer(2'b11, 8'd0, 8'd0);
        xfer(2'b10, 8'd255, 8'd0);
        xfer(2'b10, 8'd255, 8'd0);
        xfer(2'b10, 8'd255, 8'd0);
        ready_in = 1'b0;
        mode = 2'b00; a_in = 8'd9; b_in = 8'd9; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        checks++; if (valid_w !== 1'b1 || ovf_w !== 1'b1 || ready_w !== 1'b0) begin failures++; $display("FAIL rstmid_pre valid=%b ovf=%b ready=%b exp=1/1/0", valid_w, ovf_w, ready_w); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (valid_w !== 1'b0 || ovf_w !== 1'b0) begin failures++; $display("FAIL rstmid_async valid=%b ovf=%b exp=0/0", valid_w, ovf_w); end
        checks++; if (ready_w !== 1'b1 || sum_w !== 9'h000 || work_w !== 9'h000) begin failures++; $display("FAIL rstmid_state ready=%b sum=%h work=%h exp=1/000/000", ready_w, sum_w, work_w); end
        @(posedge clk); #1;
        rst = 1'b0;
        ready_in = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (valid_w !== 1'b0) begin failures++; $display("FAIL rstmid_stale valid=%b exp=0", valid_w); end
        xfer(2'b00, 8'd3, 8'd4);
        checks++; if (valid_w !== 1'b1 || sum_w !== 9'h007 || work_w !== 9'h1F8) begin failures++; $display("FAIL rstmid_after valid=%b sum=%h work=%h exp=1/007/1f8", valid_w, sum_w, work_w); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_accumulate();
        test_back_to_back();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/compute_work_pipe.md
COMPUTE_WORK_PIPE -- requirements
Module: compute_work_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits (>= 2).
REQ-002 Parameter SATURATE, default 0, 1 = accumulator saturates on overflow, 0 = accumulator wraps.
REQ-003 clk_i  input  1  single clock; all state changes on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 a_i  input  WIDTH  operand A.
REQ-006 b_i  input  WIDTH  operand B.
REQ-007 mode_i  input  2  operation: 00 add, 01 sub, 10 accumulate, 11 clear.
REQ-008 valid_i  input  1  input transaction valid.
REQ-009 ready_o  output  1  block can accept input this cycle.
REQ-010 sum_o  output  WIDTH+1  stage result.
REQ-011 work_o  output  WIDTH+1  derived work result.
REQ-012 valid_o  output  1  sum_o/work_o valid.
REQ-013 ready_i  input  1  downstream accepts output this cycle.
REQ-014 overflow_o  output  1  sticky accumulator overflow flag.

Function
REQ-015 Input accepted on rising edge when valid_i & ready_o; output consumed when valid_o & ready_i.
REQ-016 Two register stages (S1 compute, S2 work/output); latency 2 cycles from acceptance to valid_o with ready_i held high; throughput 1 transaction/cycle.
REQ-017 S2 advances when ~v2 | ready_i; S1 advances when ~v1 | S2 advances; ready_o = ~v1 | S2 advances (combinational, no registered bubble).
REQ-018 While valid_o & ~ready_i, sum_o, work_o, valid_o hold stable; no transaction lost, duplicated or reordered.
REQ-019 Add: S1 result = zero-extended a_i + b_i, WIDTH+1 bits, no truncation.
REQ-020 Sub: S1 result = a_i - b_i modulo 2^(WIDTH+1); bit WIDTH = borrow.
REQ-021 Accumulate: acc <= acc + zero-extended a_i at acceptance; S1 result = new acc value; b_i ignored.
REQ-022 Accumulator is WIDTH+1 bits; overflow = carry out of bit WIDTH on accumulate.
REQ-023 On overflow, SATURATE=0: acc wraps modulo 2^(WIDTH+1); SATURATE=1: acc and result = all ones.
REQ-024 overflow_o set on the edge accepting an overflowing accumulate; remains set until a clear is accepted.
REQ-025 Clear: acc <= 0 and overflow_o <= 0 at acceptance; S1 result = 0; clear still produces an output transaction.
REQ-026 Add/sub do not modify acc or overflow_o.
REQ-027 work_o = bitwise inverse of S2 sum with bit WIDTH forced to 1, registered alongside sum_o.
REQ-028 Accumulator updates only at acceptance; stalls never alter acc.

Reset
REQ-029 rst_i assertion immediately clears v1, v2, valid_o, acc, overflow_o, sum_o, work_o to 0 regardless of clock.
REQ-030 In-flight transactions at reset are discarded; ready_o = 1 during and after reset.
REQ-031 First acceptance possible on first rising edge after rst_i deasserts.

Verification (WIDTH=8)
REQ-032 Add a=200, b=100, ready_i=1 -> valid_o two cycles later, sum_o=0x12C, work_o=0x1D3.
REQ-033 Sub a=5, b=7 -> sum_o=0x1FE, work_o=0x101; acc, overflow_o unchanged.
REQ-034 SATURATE=0: clear, then accumulate a=255 x3 -> sums 0x0FF, 0x1FE, 0x0FD, overflow_o=1 after third; clear -> sum_o=0, overflow_o=0. SATURATE=1: third sum 0x1FF.
REQ-035 Back-to-back 3 adds with ready_i=0 -> two accepted, ready_o=0 on third, outputs stable; ready_i=1 -> all three delivered in order, no gaps after release.
REQ-036 rst_i asserted mid-cycle with v1 and v2 occupied -> valid_o=0 and overflow_o=0 immediately; no stale output after release.
